// File: rtl/and_if.sv
// Registered two-operand ALU: ADD/AND/OR/XOR with one-cycle latency,
// a carry-out for ADD and a valid strobe that follows in_valid by one clock.
module and_if #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  op_e            op_sel;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] result;

  assign op_sel = op_e'(op);
  assign sum    = {1'b0, a} + {1'b0, b};

  // result[WIDTH] is the carry bit; it stays clear for the logic ops
  always_comb begin
    result = '0;
    unique case (op_sel)
      OP_ADD: result = sum;
      OP_AND: result = {1'b0, a & b};
      OP_OR:  result = {1'b0, a | b};
      OP_XOR: result = {1'b0, a ^ b};
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y     <= result[WIDTH-1:0];
        carry <= result[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_and_if.sv
// Self-checking bench for and_if: directed scenarios followed by randomized
// traffic with asynchronous reset pulses, compared against an arithmetic model.
module tb_and_if;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned MODV  = 1 << WIDTH;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             out_valid;

  int unsigned n_cmp;
  int unsigned n_bad;

  int unsigned exp_y;
  int unsigned exp_c;
  int unsigned exp_v;

  and_if #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .y         (y),
    .carry     (carry),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: the operation as plain integer arithmetic on unsigned values.
  function automatic void model_op(input int unsigned aa, input int unsigned bb,
                                   input int unsigned oo,
                                   output int unsigned ry, output int unsigned rc);
    int unsigned s;
    case (oo)
      0: begin s = aa + bb; ry = s % MODV; rc = s / MODV; end
      1: begin ry = aa & bb; rc = 0; end
      2: begin ry = aa | bb; rc = 0; end
      default: begin ry = aa ^ bb; rc = 0; end
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".y"},         32'(y),         exp_y);
    check({tag, ".carry"},     32'(carry),     exp_c);
    check({tag, ".out_valid"}, 32'(out_valid), exp_v);
  endtask

  // Drive one cycle of input at the falling edge, predict, then check after the rising edge.
  task automatic apply(input string tag, input int unsigned aa, input int unsigned bb,
                       input int unsigned oo, input bit vv);
    int unsigned ry, rc;
    @(negedge clk);
    a        = WIDTH'(aa);
    b        = WIDTH'(bb);
    op       = 2'(oo);
    in_valid = vv;
    @(posedge clk);
    #1;
    if (vv) begin
      model_op(aa, bb, oo, ry, rc);
      exp_y = ry;
      exp_c = rc;
      exp_v = 1;
    end else begin
      exp_v = 0;
    end
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse in mid-cycle, with a valid input pending.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    op       = 2'($urandom);
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    exp_y = 0; exp_c = 0; exp_v = 0;
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    a = '0; b = '0; op = '0; in_valid = 1'b0;
    exp_y = 0; exp_c = 0; exp_v = 0;

    // Reset with no clock edge yet, then hold through three edges with valid input.
    rst = 1'b1;
    #1;
    check_outputs("rst_async");
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      a = WIDTH'($urandom); b = WIDTH'($urandom); op = 2'($urandom); in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // Wrap-around add
    apply("wrap", 4, 12, 0, 1'b1);
    check("wrap.y_lit", 32'(y), 32'd0);
    check("wrap.c_lit", 32'(carry), 32'd1);

    // Streaming, back-to-back
    apply("stream0", 2, 5, 0, 1'b1);
    check("stream0.y_lit", 32'(y), 32'd7);
    apply("stream1", 5, 7, 0, 1'b1);
    check("stream1.y_lit", 32'(y), 32'd12);

    // Logic ops on 1010 / 0110
    apply("and", 10, 6, 1, 1'b1);
    check("and.y_lit", 32'(y), 32'b0010);
    apply("or",  10, 6, 2, 1'b1);
    check("or.y_lit", 32'(y), 32'b1110);
    apply("xor", 10, 6, 3, 1'b1);
    check("xor.y_lit", 32'(y), 32'b1100);

    // Hold while idle
    apply("hold_add", 3, 4, 0, 1'b1);
    for (int unsigned i = 0; i < 5; i++) begin
      apply("hold_idle", $urandom, $urandom, $urandom_range(3), 1'b0);
    end
    check("hold.y_lit", 32'(y), 32'd7);

    // Reset mid-stream discards the in-flight result
    apply("mid_add", 9, 9, 0, 1'b1);
    reset_pulse("mid_rst");
    apply("post_rst", 1, 1, 0, 1'b1);
    check("post_rst.y_lit", 32'(y), 32'd2);

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(39) == 0) begin
        reset_pulse("rnd_rst");
      end else begin
        apply("rnd", $urandom_range(MODV - 1), $urandom_range(MODV - 1),
              $urandom_range(3), $urandom_range(3) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
